imem_loader: RTL and testbench

Byte-stream program loader for `instruction_mem`; the write-side counterpart to the fetch path that reads it. It accepts a framed byte stream: a 2-byte word count, the payload words in little-endian order, then a 1-byte XOR checksum. It assembles 32-bit words and issues one write per word into the instruction memory write port, starting at word 0. While loading, it holds the core in reset via `cpu_hold_o`.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/word_assembler.sv | 31 +++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction memory byte-stream loader.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } loader_state_e;

  // Byte address of a word index (word-aligned).
  function automatic logic [31:0] word_addr(input logic [LEN_W-1:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; pulses word_valid_o
// combinationally on the edge-qualified byte that completes a word.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane;
  logic [23:0] sr;

  // Lane 3 is never stored: it is the byte arriving with the word_valid pulse.
  assign word_valid_o = byte_en_i && (lane == 2'd3);
  assign word_o       = {byte_i, sr};

  // Shift bytes in from the top so lane 0 ends up in bits [7:0].
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      lane <= 2'd0;
      sr   <= 24'd0;
    end else if (byte_en_i) begin
      lane <= lane + 2'd1;
      sr   <= {byte_i, sr[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: length, little-endian payload words, XOR checksum.
// Writes each assembled word to the instruction memory and holds the core
// in reset until a load finishes cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_SIZE = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  loader_state_e     state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  word_cnt;
  logic [CSUM_W-1:0] csum;
  logic              accept;
  logic              restart;
  logic [LEN_W-1:0]  len_full;
  logic [31:0]       asm_word;
  logic              asm_valid;

  assign accept   = byte_valid_i && byte_ready_o;
  assign restart  = start_i && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign len_full = {byte_data_i, len[7:0]};

  word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (restart),
    .byte_en_i    (accept && state == S_DATA),
    .byte_i       (byte_data_i),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  // Loader FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      len          <= '0;
      word_cnt     <= '0;
      csum         <= '0;
      byte_ready_o <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      cpu_hold_o   <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state        <= S_LEN_LO;
            len          <= '0;
            word_cnt     <= '0;
            csum         <= '0;
            byte_ready_o <= 1'b1;
            cpu_hold_o   <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data_i;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len <= len_full;
            if (len_full == '0 || len_full > LEN_W'(MEM_SIZE)) begin
              state        <= S_ERR;
              byte_ready_o <= 1'b0;
              err_o        <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ byte_data_i;
            if (asm_valid) begin
              wr_en_o   <= 1'b1;
              wr_addr_o <= word_addr(word_cnt);
              wr_data_o <= asm_word;
              word_cnt  <= word_cnt + 1'b1;
              if (word_cnt + 1'b1 == len) state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            byte_ready_o <= 1'b0;
            if (byte_data_i == csum) begin
              state      <= S_DONE;
              done_o     <= 1'b1;
              cpu_hold_o <= 1'b0;
            end else begin
              state <= S_ERR;
              err_o <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_i, start_i, byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o, wr_en_o, cpu_hold_o, done_o, err_o;
  logic [31:0] wr_addr_o, wr_data_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] wq[$];     // observed writes {addr, data}
  logic [7:0]  stream[$]; // bytes to push into the DUT
  logic [31:0] words[$];  // model payload words
  logic [7:0]  model_cs;

  imem_loader #(.MEM_SIZE(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .cpu_hold_o   (cpu_hold_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en_o) wq.push_back({wr_addr_o, wr_data_o});

  // Model: frame = len(2, LE) + words (LE bytes) + xor checksum of payload.
  task automatic build_frame(input int n);
    logic [31:0] w;
    stream.delete();
    model_cs = 8'h00;
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        stream.push_back(w[8*b +: 8]);
        model_cs = model_cs ^ w[8*b +: 8];
      end
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start;
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  // Push stream[from..to-1] honouring ready, with random valid gaps.
  task automatic send(input int from, input int to, input int pct);
    int idx = from;
    int cyc = 0;
    logic acc;
    while (idx < to) begin
      byte_valid_i = ($urandom_range(99) < pct);
      byte_data_i  = byte_valid_i ? stream[idx] : 8'($urandom);
      acc = byte_valid_i && byte_ready_o;
      tick();
      if (acc) idx++;
      cyc++;
      if (cyc > 5000) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: accepted %0d bytes, required %0d", idx - from, to - from);
        break;
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic check_writes(input string name);
    n_cmp++;
    if (wq.size() != words.size()) begin
      n_err++;
      $display("FAIL %s_wcount: got %0d writes, expected %0d", name, wq.size(), words.size());
    end
    for (int i = 0; i < words.size() && i < wq.size(); i++) begin
      n_cmp++;
      if (wq[i] !== {32'(i * 4), words[i]}) begin
        n_err++;
        $display("FAIL %s_write%0d: got %h, expected %h", name, i, wq[i], {32'(i * 4), words[i]});
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
    repeat (3) tick();
    n_cmp++;
    if ({byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o} !== 69'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h h=%b dn=%b er=%b, expected all 0",
               byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o);
    end
    rst_i = 1'b0; tick();
  endtask

  // Full load with supplied checksum; expectation derived from the model checksum.
  task automatic run_load(input string name, input int pct, input logic use_bad, input logic [7:0] bad_cs);
    logic [7:0] cs;
    logic good;
    wq.delete();
    build_frame(words.size());
    cs = use_bad ? bad_cs : model_cs;
    good = (cs == model_cs);
    stream.push_back(cs);
    pulse_start();
    n_cmp++;
    if (byte_ready_o !== 1'b1 || cpu_hold_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_start: rdy=%b hold=%b done=%b err=%b, expected 1 1 0 0", name, byte_ready_o, cpu_hold_o, done_o, err_o);
    end
    send(0, stream.size(), pct);
    n_cmp++;
    if (done_o !== good || err_o !== !good || cpu_hold_o !== !good || byte_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_end: done=%b err=%b hold=%b rdy=%b, expected %b %b %b 0",
               name, done_o, err_o, cpu_hold_o, byte_ready_o, good, !good, !good);
    end
    check_writes(name);
  endtask

  task automatic test_two_word;
    words.delete(); words.push_back(32'h00518193); words.push_back(32'h00a20213);
    run_load("two_word", 100, 1'b0, 8'h00);
  endtask

  task automatic test_bad_checksum;
    words.delete(); words.push_back(32'h00518193); words.push_back(32'h00a20213);
    run_load("bad_cs", 100, 1'b1, 8'h00);
  endtask

  task automatic test_bad_len(input logic [7:0] lo, input logic [7:0] hi);
    wq.delete();
    stream.delete(); stream.push_back(lo); stream.push_back(hi);
    pulse_start();
    send(0, 2, 100);
    n_cmp++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || cpu_hold_o !== 1'b1 || byte_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL bad_len_%h%h: err=%b done=%b hold=%b rdy=%b, expected 1 0 1 0", hi, lo, err_o, done_o, cpu_hold_o, byte_ready_o);
    end
    repeat (3) tick();
    n_cmp++;
    if (wq.size() != 0) begin
      n_err++;
      $display("FAIL bad_len_writes: got %0d writes, expected 0", wq.size());
    end
  endtask

  task automatic test_full_random;
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back($urandom);
    run_load("full64", 60, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_load;
    words.delete(); words.push_back(32'h11223344); words.push_back(32'h55667788);
    wq.delete();
    build_frame(2);
    pulse_start();
    send(0, 8, 100);   // length + 6 payload bytes
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    n_cmp++;
    if ({byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o} !== 69'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: rdy=%b we=%b a=%h d=%h h=%b dn=%b er=%b, expected all 0",
               byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o);
    end
    repeat (4) tick();
    n_cmp++;
    if (wq.size() != 1 || wq[0] !== {32'h0, 32'h11223344}) begin
      n_err++;
      $display("FAIL midrst_writes: got %0d writes (first %h), expected 1 at 0 data 11223344",
               wq.size(), wq.size() > 0 ? wq[0] : 64'h0);
    end
  endtask

  task automatic test_start_ignored_and_restart;
    words.delete(); words.push_back($urandom); words.push_back($urandom);
    wq.delete();
    build_frame(2);
    stream.push_back(model_cs);
    pulse_start();
    send(0, 5, 100);
    pulse_start();    // in DATA: must be ignored
    n_cmp++;
    if (byte_ready_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_data: rdy=%b hold=%b, expected 1 1", byte_ready_o, cpu_hold_o);
    end
    send(5, stream.size(), 80);
    n_cmp++;
    if (done_o !== 1'b1 || err_o !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_data_done: done=%b err=%b, expected 1 0", done_o, err_o);
    end
    check_writes("start_in_data");
    pulse_start();    // in DONE: restarts
    n_cmp++;
    if (byte_ready_o !== 1'b1 || done_o !== 1'b0 || cpu_hold_o !== 1'b1) begin
      n_err++;
      $display("FAIL restart_from_done: rdy=%b done=%b hold=%b, expected 1 0 1", byte_ready_o, done_o, cpu_hold_o);
    end
    // back-to-back: complete a one-word load on the restarted frame
    words.delete(); words.push_back($urandom);
    wq.delete();
    build_frame(1);
    stream.push_back(model_cs);
    send(0, stream.size(), 70);
    n_cmp++;
    if (done_o !== 1'b1 || cpu_hold_o !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_back: done=%b hold=%b, expected 1 0", done_o, cpu_hold_o);
    end
    check_writes("back_to_back");
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_bad_len(8'h00, 8'h00);
    test_bad_len(8'h41, 8'h00);
    test_full_random();
    test_reset_mid_load();
    test_start_ignored_and_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
